// File: rtl/cv32e40p_nmr_voter_monitor_if.sv
// Sample and result bundle between the replicated execution units and the
// N-modular-redundancy voter. The voter connects to the slave side; whoever
// produces replica samples and consumes results connects to the master side.
interface cv32e40p_nmr_voter_monitor_if #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned NUM_REPLICAS = 3,
   parameter int unsigned CNT_WIDTH    = 8
);
   logic                               valid_i;
   logic [NUM_REPLICAS*DATA_WIDTH-1:0] data_i;
   logic                               cnt_clr_i;
   logic                               irq_ack_i;

   logic                               valid_o;
   logic [DATA_WIDTH-1:0]              winner_o;
   logic                               fault_o;
   logic                               uncorrectable_o;
   logic [NUM_REPLICAS-1:0]            dead_o;
   logic                               degraded_o;
   logic [CNT_WIDTH-1:0]               fault_cnt_o;
   logic                               irq_o;

   modport master (
      output valid_i, data_i, cnt_clr_i, irq_ack_i,
      input  valid_o, winner_o, fault_o, uncorrectable_o,
             dead_o, degraded_o, fault_cnt_o, irq_o
   );

   modport slave (
      input  valid_i, data_i, cnt_clr_i, irq_ack_i,
      output valid_o, winner_o, fault_o, uncorrectable_o,
             dead_o, degraded_o, fault_cnt_o, irq_o
   );
endinterface

// File: rtl/cv32e40p_nmr_voter_monitor.sv
// N-modular-redundancy voter with per-replica fault bookkeeping.
// Replica words are voted bitwise over the live replicas. A replica that
// disagrees with the vote for FAULT_THRESHOLD consecutive correctable samples
// is retired permanently (until reset). All results are registered, so a
// sample taken at edge k is reported in cycle k+1.
// NUM_REPLICAS is expected to be odd in 3..7, FAULT_THRESHOLD in 1..15, and
// the interface instance must use the same DATA_WIDTH/NUM_REPLICAS/CNT_WIDTH.
module cv32e40p_nmr_voter_monitor #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned NUM_REPLICAS    = 3,
   parameter int unsigned FAULT_THRESHOLD = 4,
   parameter int unsigned CNT_WIDTH       = 8
) (
   input logic                          clk,
   input logic                          rst,
   cv32e40p_nmr_voter_monitor_if.slave  bus
);

   localparam int unsigned CW = $clog2(FAULT_THRESHOLD + 1);
   localparam int unsigned NW = $clog2(NUM_REPLICAS + 1);
   localparam logic [CW-1:0] THR = CW'(FAULT_THRESHOLD);

   // registered state
   logic                    valid_q,  valid_d;
   logic [DATA_WIDTH-1:0]   winner_q, winner_d;
   logic                    fault_q,  fault_d;
   logic                    unc_q,    unc_d;
   logic [NUM_REPLICAS-1:0] dead_q,   dead_d;
   logic [CNT_WIDTH-1:0]    fcnt_q,   fcnt_d;
   logic                    irq_q,    irq_d;
   logic [CW-1:0]           cnt_q [NUM_REPLICAS];
   logic [CW-1:0]           cnt_d [NUM_REPLICAS];

   // combinational sample evaluation
   logic [NUM_REPLICAS-1:0] live;
   logic [DATA_WIDTH-1:0]   vote;
   logic [DATA_WIDTH-1:0]   tie_bit;
   logic                    tie_any;
   logic [NUM_REPLICAS-1:0] mismatch;
   logic [NUM_REPLICAS-1:0] hit;
   logic [NUM_REPLICAS-1:0] retire;
   logic                    block;
   logic                    sample_unc;
   logic                    sample_fault;

   assign live    = ~dead_q;
   assign tie_any = |tie_bit;

   for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
      logic [NW-1:0] ones;
      logic [NW-1:0] zeros;
      logic          first;

      // Per-bit population count over live replicas; on a tie the
      // lowest-index live replica decides the bit.
      always_comb begin
         ones  = '0;
         zeros = '0;
         first = 1'b0;
         for (int r = NUM_REPLICAS - 1; r >= 0; r--) begin
            if (live[r]) begin
               first = bus.data_i[r*DATA_WIDTH + b];
               if (bus.data_i[r*DATA_WIDTH + b]) begin
                  ones = ones + NW'(1);
               end else begin
                  zeros = zeros + NW'(1);
               end
            end
         end
      end

      assign tie_bit[b] = (ones == zeros);
      assign vote[b]    = (ones == zeros) ? first : (ones > zeros);
   end

   // A replica mismatches when it is live and its whole word differs from the vote.
   always_comb begin
      mismatch = '0;
      for (int r = 0; r < NUM_REPLICAS; r++) begin
         mismatch[r] = live[r] && (bus.data_i[r*DATA_WIDTH +: DATA_WIDTH] != vote);
      end
   end

   // Consecutive-mismatch counters and retirement decision. A tie freezes
   // counting because the vote itself cannot be trusted. Counters may still
   // sit at the threshold after a blocked retirement, so the next mismatch
   // on that replica retries the retirement.
   always_comb begin
      cnt_d = cnt_q;
      hit   = '0;
      for (int r = 0; r < NUM_REPLICAS; r++) begin
         if (bus.valid_i && live[r] && !tie_any) begin
            if (mismatch[r]) begin
               if (cnt_q[r] != THR) begin
                  cnt_d[r] = cnt_q[r] + CW'(1);
               end
               hit[r] = (cnt_d[r] == THR);
            end else begin
               cnt_d[r] = '0;
            end
         end
      end
      block        = (|hit) && (&(dead_q | hit));
      retire       = block ? '0 : hit;
      sample_unc   = bus.valid_i && (tie_any || block);
      sample_fault = bus.valid_i && ((|mismatch) || tie_any || block);
   end

   // Next values for the result, retirement, fault-count and interrupt registers.
   always_comb begin
      valid_d  = bus.valid_i;
      winner_d = winner_q;
      fault_d  = 1'b0;
      unc_d    = 1'b0;
      dead_d   = dead_q | retire;
      fcnt_d   = fcnt_q;
      irq_d    = irq_q;
      if (bus.valid_i) begin
         winner_d = vote;
         fault_d  = sample_fault;
         unc_d    = sample_unc;
      end
      if (sample_fault) begin
         if (bus.cnt_clr_i) begin
            fcnt_d = CNT_WIDTH'(1);
         end else if (!(&fcnt_q)) begin
            fcnt_d = fcnt_q + CNT_WIDTH'(1);
         end
      end else if (bus.cnt_clr_i) begin
         fcnt_d = '0;
      end
      if (|retire) begin
         irq_d = 1'b1;
      end else if (bus.irq_ack_i) begin
         irq_d = 1'b0;
      end
   end

   // State register with synchronous reset taking priority over any sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         winner_q <= '0;
         fault_q  <= 1'b0;
         unc_q    <= 1'b0;
         dead_q   <= '0;
         fcnt_q   <= '0;
         irq_q    <= 1'b0;
         for (int r = 0; r < NUM_REPLICAS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         winner_q <= winner_d;
         fault_q  <= fault_d;
         unc_q    <= unc_d;
         dead_q   <= dead_d;
         fcnt_q   <= fcnt_d;
         irq_q    <= irq_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.valid_o         = valid_q;
   assign bus.winner_o        = winner_q;
   assign bus.fault_o         = fault_q;
   assign bus.uncorrectable_o = unc_q;
   assign bus.dead_o          = dead_q;
   assign bus.degraded_o      = |dead_q;
   assign bus.fault_cnt_o     = fcnt_q;
   assign bus.irq_o           = irq_q;

endmodule

// File: tb/tb_cv32e40p_nmr_voter_monitor.sv
// Directed bench for the NMR voter. Each step pushes its expected result to
// a scoreboard queue when the sample is driven, and the entry is popped and
// compared once the registered result is visible. A second instance with a
// 2-bit fault counter covers counter saturation and clear.
module tb_cv32e40p_nmr_voter_monitor;

   typedef struct packed {
      logic        valid;
      logic [31:0] win;
      logic        fault;
      logic        unc;
      logic [2:0]  dead;
      logic        deg;
      logic [7:0]  cnt;
      logic        irq;
   } exp_t;

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] GB = 32'h0BADF00D;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];

   cv32e40p_nmr_voter_monitor_if #(.DATA_WIDTH(32), .NUM_REPLICAS(3), .CNT_WIDTH(8)) bus_a ();
   cv32e40p_nmr_voter_monitor_if #(.DATA_WIDTH(32), .NUM_REPLICAS(3), .CNT_WIDTH(2)) bus_b ();

   cv32e40p_nmr_voter_monitor #(
      .DATA_WIDTH(32), .NUM_REPLICAS(3), .FAULT_THRESHOLD(4), .CNT_WIDTH(8)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   cv32e40p_nmr_voter_monitor #(
      .DATA_WIDTH(32), .NUM_REPLICAS(3), .FAULT_THRESHOLD(4), .CNT_WIDTH(2)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t ex(input logic v, input logic [31:0] w, input logic f,
                               input logic u, input logic [2:0] d, input logic [7:0] c,
                               input logic i);
      exp_t e;
      e.valid = v;
      e.win   = w;
      e.fault = f;
      e.unc   = u;
      e.dead  = d;
      e.deg   = |d;
      e.cnt   = c;
      e.irq   = i;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_a(input string tag);
      exp_t e;
      if (sb_a.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = sb_a.pop_front();
         chk({tag, ".valid"},  32'(bus_a.valid_o),         32'(e.valid));
         chk({tag, ".winner"}, bus_a.winner_o,              e.win);
         chk({tag, ".fault"},  32'(bus_a.fault_o),         32'(e.fault));
         chk({tag, ".unc"},    32'(bus_a.uncorrectable_o), 32'(e.unc));
         chk({tag, ".dead"},   32'(bus_a.dead_o),          32'(e.dead));
         chk({tag, ".deg"},    32'(bus_a.degraded_o),      32'(e.deg));
         chk({tag, ".fcnt"},   32'(bus_a.fault_cnt_o),     32'(e.cnt));
         chk({tag, ".irq"},    32'(bus_a.irq_o),           32'(e.irq));
      end
   endtask

   task automatic drive_a(input string tag, input logic r, input logic v,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic clr, input logic ack, input exp_t e);
      @(negedge clk);
      rst             = r;
      bus_a.valid_i   = v;
      bus_a.data_i    = {d2, d1, d0};
      bus_a.cnt_clr_i = clr;
      bus_a.irq_ack_i = ack;
      bus_b.valid_i   = 1'b0;
      bus_b.cnt_clr_i = 1'b0;
      sb_a.push_back(e);
      @(posedge clk);
      #1;
      check_a(tag);
   endtask

   task automatic drive_b(input string tag, input logic v,
                          input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                          input logic clr, input logic [7:0] exp_cnt, input logic exp_fault);
      exp_t e;
      e = ex(v, 32'h0, exp_fault, 1'b0, 3'b000, exp_cnt, 1'b0);
      @(negedge clk);
      rst             = 1'b0;
      bus_a.valid_i   = 1'b0;
      bus_a.cnt_clr_i = 1'b0;
      bus_a.irq_ack_i = 1'b0;
      bus_b.valid_i   = v;
      bus_b.data_i    = {d2, d1, d0};
      bus_b.cnt_clr_i = clr;
      bus_b.irq_ack_i = 1'b0;
      sb_b.push_back(e);
      @(posedge clk);
      #1;
      e = sb_b.pop_front();
      chk({tag, ".fcnt"},  32'(bus_b.fault_cnt_o), 32'(e.cnt));
      chk({tag, ".fault"}, 32'(bus_b.fault_o),     32'(e.fault));
      chk({tag, ".dead"},  32'(bus_b.dead_o),      32'(e.dead));
   endtask

   initial begin
      rst             = 1'b1;
      bus_a.valid_i   = 1'b0;
      bus_a.data_i    = '0;
      bus_a.cnt_clr_i = 1'b0;
      bus_a.irq_ack_i = 1'b0;
      bus_b.valid_i   = 1'b0;
      bus_b.data_i    = '0;
      bus_b.cnt_clr_i = 1'b0;
      bus_b.irq_ack_i = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      sb_a.push_back(ex(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0));
      check_a("reset");

      // all replicas agree
      for (int i = 0; i < 10; i++)
         drive_a("clean", 1'b0, 1'b1, DB, DB, DB, 1'b0, 1'b0,
                 ex(1'b1, DB, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0));

      // replica 1 corrupted 3, clean 1, corrupted 3: never reaches threshold
      for (int i = 1; i <= 3; i++)
         drive_a("r1_bad_a", 1'b0, 1'b1, DB, DB ^ 32'h1, DB, 1'b0, 1'b0,
                 ex(1'b1, DB, 1'b1, 1'b0, 3'b000, 8'(i), 1'b0));
      drive_a("r1_gap", 1'b0, 1'b1, DB, DB, DB, 1'b0, 1'b0,
              ex(1'b1, DB, 1'b0, 1'b0, 3'b000, 8'd3, 1'b0));
      for (int i = 4; i <= 6; i++)
         drive_a("r1_bad_b", 1'b0, 1'b1, DB, DB ^ 32'h1, DB, 1'b0, 1'b0,
                 ex(1'b1, DB, 1'b1, 1'b0, 3'b000, 8'(i), 1'b0));

      // replica 2 corrupted 4 times: retired on the 4th
      for (int i = 1; i <= 4; i++)
         drive_a("r2_retire", 1'b0, 1'b1, DB, DB, GB, 1'b0, 1'b0,
                 ex(1'b1, DB, 1'b1, 1'b0, (i == 4) ? 3'b100 : 3'b000, 8'(6 + i), (i == 4)));
      drive_a("irq_sticky", 1'b0, 1'b1, DB, DB, GB, 1'b0, 1'b0,
              ex(1'b1, DB, 1'b0, 1'b0, 3'b100, 8'd10, 1'b1));
      drive_a("irq_ack", 1'b0, 1'b1, DB, DB, GB, 1'b0, 1'b1,
              ex(1'b1, DB, 1'b0, 1'b0, 3'b100, 8'd10, 1'b0));
      drive_a("idle_hold", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
              ex(1'b0, DB, 1'b0, 1'b0, 3'b100, 8'd10, 1'b0));

      // two live replicas disagree on bit 5: tie, replica 0 wins, no counting
      for (int i = 1; i <= 5; i++)
         drive_a("tie_bit5", 1'b0, 1'b1, DB, DB ^ 32'h20, GB, 1'b0, 1'b0,
                 ex(1'b1, DB, 1'b1, 1'b1, 3'b100, 8'(10 + i), 1'b0));

      // reset mid-stream discards the in-flight sample
      drive_a("mid_reset", 1'b1, 1'b1, DB, DB ^ 32'h1, DB, 1'b0, 1'b0,
              ex(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 8'd0, 1'b0));

      // all three replicas reach threshold together: retirement blocked
      for (int i = 1; i <= 4; i++)
         drive_a("all_bad", 1'b0, 1'b1, DB ^ 32'h1, DB ^ 32'h2, DB ^ 32'h4, 1'b0, 1'b0,
                 ex(1'b1, DB, 1'b1, (i == 4), 3'b000, 8'(i), 1'b0));

      // a retirement coinciding with an ack keeps irq set
      drive_a("retire_ack", 1'b0, 1'b1, DB ^ 32'h1, DB, DB, 1'b0, 1'b1,
              ex(1'b1, DB, 1'b1, 1'b0, 3'b001, 8'd5, 1'b1));
      drive_a("r0_dead", 1'b0, 1'b1, DB ^ 32'h1, DB, DB, 1'b0, 1'b0,
              ex(1'b1, DB, 1'b0, 1'b0, 3'b001, 8'd5, 1'b1));

      // 2-bit fault counter saturates at 3, clear with a faulty sample gives 1
      for (int i = 1; i <= 3; i++)
         drive_b("b_sat_r1", 1'b1, DB, DB ^ 32'h1, DB, 1'b0, 8'(i), 1'b1);
      for (int i = 4; i <= 5; i++)
         drive_b("b_sat_r2", 1'b1, DB, DB, DB ^ 32'h1, 1'b0, 8'd3, 1'b1);
      drive_b("b_clr_fault", 1'b1, DB, DB, DB ^ 32'h1, 1'b1, 8'd1, 1'b1);
      drive_b("b_clr_idle", 1'b0, DB, DB, DB, 1'b1, 8'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
